// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding imem fetch, gshare branch prediction
// and the IF/ID pipeline register feeding decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_rdata,
  input  logic        id_stall,
  input  logic        id_redirect_valid,
  input  logic [31:0] id_redirect_addr,
  input  logic        ex_redirect_valid,
  input  logic [31:0] ex_redirect_addr,
  input  logic        ex_redirect_trap,
  input  logic        ex_pht_update_valid,
  input  logic [5:0]  ex_pht_idx,
  input  logic        ex_branch_taken,
  output logic        id_q_valid,
  output logic [31:0] id_q_insn,
  output logic [31:0] id_q_pc,
  output logic [31:0] id_q_pc_plus_4,
  output logic        id_q_intr,
  output logic        id_predict_btaken,
  output logic [5:0]  id_pht_idx
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fpc;
  logic        drop;
  logic        intr_pending;
  logic [31:0] hold_insn;
  logic        hold_btaken;
  logic [5:0]  hold_idx;
  logic [1:0]  pht [64];
  logic [5:0]  ghr;

  logic        redirect;
  logic [31:0] redirect_addr;
  logic [5:0]  look_idx;
  logic        look_btaken;
  logic        rsp_load;
  logic        hold_load;
  logic        q_load;
  logic [1:0]  upd_ctr;

  always_comb begin
    redirect      = ex_redirect_valid | (id_redirect_valid & ~id_stall);
    redirect_addr = ex_redirect_valid ? ex_redirect_addr : id_redirect_addr;
    look_idx      = fpc[7:2] ^ ghr;
    look_btaken   = (imem_rsp_rdata[6:0] == 7'b1100011) & pht[look_idx][1];
    rsp_load      = (state == S_WAIT) & imem_rsp_valid & ~drop & ~redirect & ~id_stall;
    hold_load     = (state == S_HOLD) & ~id_stall & ~redirect;
    q_load        = rsp_load | hold_load;
    upd_ctr       = pht[ex_pht_idx];
  end

  assign imem_req_valid = (state == S_REQ) & ~redirect & ~rst;
  assign imem_req_addr  = pc;

  // Non-speculative predictor state: only resolved EX outcomes train it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pht <= '{default: 2'b01};
      ghr <= '0;
    end else if (ex_pht_update_valid) begin
      if (ex_branch_taken && upd_ctr != 2'b11)
        pht[ex_pht_idx] <= upd_ctr + 2'd1;
      else if (!ex_branch_taken && upd_ctr != 2'b00)
        pht[ex_pht_idx] <= upd_ctr - 2'd1;
      ghr <= {ghr[4:0], ex_branch_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      fpc          <= RESET_PC;
      drop         <= 1'b0;
      intr_pending <= 1'b0;
      hold_insn    <= '0;
      hold_btaken  <= 1'b0;
      hold_idx     <= '0;
    end else begin
      if (ex_redirect_valid && ex_redirect_trap)
        intr_pending <= 1'b1;
      else if (q_load)
        intr_pending <= 1'b0;

      case (state)
        S_REQ: begin
          if (redirect) begin
            pc <= redirect_addr;
          end else if (imem_req_ready) begin
            fpc   <= pc;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A redirect coinciding with the response consumes that response
          // directly; drop is only needed while the stale response is still due.
          if (imem_rsp_valid) begin
            drop <= 1'b0;
            if (redirect) begin
              pc    <= redirect_addr;
              state <= S_REQ;
            end else if (drop) begin
              state <= S_REQ;
            end else if (!id_stall) begin
              pc    <= fpc + 32'd4;
              state <= S_REQ;
            end else begin
              hold_insn   <= imem_rsp_rdata;
              hold_btaken <= look_btaken;
              hold_idx    <= look_idx;
              state       <= S_HOLD;
            end
          end else if (redirect) begin
            pc   <= redirect_addr;
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= redirect_addr;
            state <= S_REQ;
          end else if (!id_stall) begin
            pc    <= fpc + 32'd4;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q_valid        <= 1'b0;
      id_q_insn         <= '0;
      id_q_pc           <= '0;
      id_q_pc_plus_4    <= '0;
      id_q_intr         <= 1'b0;
      id_predict_btaken <= 1'b0;
      id_pht_idx        <= '0;
    end else if (ex_redirect_valid) begin
      id_q_valid <= 1'b0;
      id_q_intr  <= 1'b0;
    end else if (q_load) begin
      id_q_valid        <= 1'b1;
      id_q_insn         <= hold_load ? hold_insn : imem_rsp_rdata;
      id_q_pc           <= fpc;
      id_q_pc_plus_4    <= fpc + 32'd4;
      id_q_intr         <= intr_pending;
      id_predict_btaken <= hold_load ? hold_btaken : look_btaken;
      id_pht_idx        <= hold_load ? hold_idx : look_idx;
    end else if (!id_stall) begin
      id_q_valid <= 1'b0;
      id_q_intr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a transaction-level model of the expected fetch stream and predictor.
module tb_if_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_rdata = '0;
  logic        id_stall = 1'b0, id_redirect_valid = 1'b0, ex_redirect_valid = 1'b0;
  logic [31:0] id_redirect_addr = '0, ex_redirect_addr = '0;
  logic        ex_redirect_trap = 1'b0, ex_pht_update_valid = 1'b0, ex_branch_taken = 1'b0;
  logic [5:0]  ex_pht_idx = '0;
  logic        id_q_valid, id_q_intr, id_predict_btaken;
  logic [31:0] id_q_insn, id_q_pc, id_q_pc_plus_4;
  logic [5:0]  id_pht_idx;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_rdata(imem_rsp_rdata),
    .id_stall(id_stall), .id_redirect_valid(id_redirect_valid), .id_redirect_addr(id_redirect_addr),
    .ex_redirect_valid(ex_redirect_valid), .ex_redirect_addr(ex_redirect_addr),
    .ex_redirect_trap(ex_redirect_trap), .ex_pht_update_valid(ex_pht_update_valid),
    .ex_pht_idx(ex_pht_idx), .ex_branch_taken(ex_branch_taken),
    .id_q_valid(id_q_valid), .id_q_insn(id_q_insn), .id_q_pc(id_q_pc),
    .id_q_pc_plus_4(id_q_pc_plus_4), .id_q_intr(id_q_intr),
    .id_predict_btaken(id_predict_btaken), .id_pht_idx(id_pht_idx)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [31:0] imem [0:255];
  int unsigned lat_min = 1, lat_max = 1;
  bit          rdy_rand = 1'b0;
  bit          pend = 1'b0;
  int unsigned pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          acc_seen, req_seen, stall_seen, new_entry;
  logic [31:0] acc_addr;

  // One clock: sample pre-edge request/stall, advance, then play the memory.
  task automatic step();
    #1;
    acc_seen   = imem_req_valid & imem_req_ready;
    req_seen   = imem_req_valid;
    acc_addr   = imem_req_addr;
    stall_seen = id_stall;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (acc_seen) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_cnt  = $urandom_range(lat_max, lat_min);
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_rdata = imem[pend_addr[9:2]];
        pend = 1'b0;
      end
    end
    imem_req_ready = rdy_rand ? ($urandom_range(1, 0) != 0) : 1'b1;
    new_entry = id_q_valid & ~stall_seen;
  endtask

  task automatic wait_entry(input int unsigned max, output bit ok);
    ok = 1'b0;
    for (int unsigned k = 0; k < max && !ok; k++) begin
      step();
      if (new_entry) ok = 1'b1;
    end
  endtask

  task automatic wait_acc(input logic [31:0] a, input int unsigned max, output bit ok);
    ok = 1'b0;
    for (int unsigned k = 0; k < max && !ok; k++) begin
      step();
      if (acc_seen && acc_addr == a) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; id_stall = 1'b0; id_redirect_valid = 1'b0; ex_redirect_valid = 1'b0;
    ex_redirect_trap = 1'b0; ex_pht_update_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic test_reset();
    fill_nops();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (req_seen !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", req_seen); end
    n_checks++;
    if ({id_q_valid, id_q_intr, id_predict_btaken, id_pht_idx} !== 9'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0", {id_q_valid, id_q_intr, id_predict_btaken, id_pht_idx});
    end
    n_checks++;
    if ({id_q_insn, id_q_pc, id_q_pc_plus_4} !== 96'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {id_q_insn, id_q_pc, id_q_pc_plus_4});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (!(acc_seen && acc_addr === 32'h0)) begin
      n_fail++; $display("FAIL first_req: got valid %b addr %h expected 1 addr 00000000", acc_seen, acc_addr);
    end
  endtask

  task automatic test_sequential();
    int unsigned n, c, last;
    fill_nops();
    lat_min = 1; lat_max = 1; rdy_rand = 1'b0;
    do_reset();
    n = 0; c = 0; last = 0;
    for (int unsigned k = 0; k < 20 && n < 4; k++) begin
      step();
      c++;
      if (new_entry) begin
        n_checks++;
        if (id_q_pc !== 32'(n * 4) || id_q_pc_plus_4 !== 32'(n * 4 + 4) || id_q_insn !== 32'h13) begin
          n_fail++; $display("FAIL seq_entry: got pc %h pc4 %h insn %h expected pc %h", id_q_pc, id_q_pc_plus_4, id_q_insn, 32'(n * 4));
        end
        n_checks++;
        if (id_predict_btaken !== 1'b0) begin n_fail++; $display("FAIL seq_btaken: got %b expected 0", id_predict_btaken); end
        n_checks++;
        if (c - last !== (n == 0 ? 32'd2 : 32'd2)) begin
          n_fail++; $display("FAIL seq_interval: got %0d expected 2", c - last);
        end
        last = c;
        n++;
      end
    end
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL seq_count: got %0d expected 4", n); end
  endtask

  task automatic test_stall_hold();
    bit ok;
    logic s_valid;
    logic [31:0] s_pc;
    fill_nops();
    do_reset();
    wait_acc(32'h8, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hold_acc: got none expected request 00000008"); end
    id_stall = 1'b1;
    s_valid = id_q_valid;
    s_pc = id_q_pc;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (req_seen !== 1'b0 || id_q_valid !== s_valid || id_q_pc !== s_pc) begin
        n_fail++; $display("FAIL hold_stalled: got req %b valid %b pc %h expected req 0 valid %b pc %h", req_seen, id_q_valid, id_q_pc, s_valid, s_pc);
      end
    end
    id_stall = 1'b0;
    step();
    n_checks++;
    if (!(new_entry && id_q_pc === 32'h8)) begin
      n_fail++; $display("FAIL hold_release: got new %b pc %h expected 1 pc 00000008", new_entry, id_q_pc);
    end
    step();
    n_checks++;
    if (!(acc_seen && acc_addr === 32'hC)) begin
      n_fail++; $display("FAIL hold_next_req: got %b addr %h expected 1 addr 0000000c", acc_seen, acc_addr);
    end
  endtask

  task automatic test_drop();
    bit ok;
    fill_nops();
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_acc(32'h10, 60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drop_acc: got none expected request 00000010"); end
    ex_redirect_valid = 1'b1; ex_redirect_addr = 32'h100;
    step();
    ex_redirect_valid = 1'b0;
    ok = 1'b0;
    for (int unsigned k = 0; k < 20 && !ok; k++) begin
      n_checks++;
      if (id_q_valid !== 1'b0) begin n_fail++; $display("FAIL drop_bubble: got valid %b pc %h expected 0", id_q_valid, id_q_pc); end
      step();
      if (acc_seen) ok = 1'b1;
    end
    n_checks++;
    if (!(ok && acc_addr === 32'h100)) begin
      n_fail++; $display("FAIL drop_new_req: got %b addr %h expected 1 addr 00000100", ok, acc_addr);
    end
    wait_entry(20, ok);
    n_checks++;
    if (!(ok && id_q_pc === 32'h100)) begin
      n_fail++; $display("FAIL drop_entry: got %b pc %h expected 1 pc 00000100", ok, id_q_pc);
    end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_pht_training();
    bit ok;
    fill_nops();
    imem[2]  = 32'hFE00_0EE3;
    imem[25] = 32'hFE00_0EE3;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ex_pht_update_valid = 1'b1; ex_pht_idx = 6'd5; ex_branch_taken = 1'b1;
      step();
    end
    ex_pht_update_valid = 1'b0;
    ex_redirect_valid = 1'b1; ex_redirect_addr = 32'h8;
    step();
    ex_redirect_valid = 1'b0;
    wait_entry(20, ok);
    n_checks++;
    if (!(ok && id_q_pc === 32'h8 && id_predict_btaken === 1'b1 && id_pht_idx === 6'd5)) begin
      n_fail++; $display("FAIL pht_taken: got pc %h btaken %b idx %0d expected pc 00000008 btaken 1 idx 5", id_q_pc, id_predict_btaken, id_pht_idx);
    end
    for (int k = 0; k < 2; k++) begin
      ex_pht_update_valid = 1'b1; ex_pht_idx = 6'd5; ex_branch_taken = 1'b0;
      step();
    end
    ex_pht_update_valid = 1'b0;
    ex_redirect_valid = 1'b1; ex_redirect_addr = 32'h64;
    step();
    ex_redirect_valid = 1'b0;
    wait_entry(20, ok);
    n_checks++;
    if (!(ok && id_q_pc === 32'h64 && id_predict_btaken === 1'b0 && id_pht_idx === 6'd5)) begin
      n_fail++; $display("FAIL pht_not_taken: got pc %h btaken %b idx %0d expected pc 00000064 btaken 0 idx 5", id_q_pc, id_predict_btaken, id_pht_idx);
    end
  endtask

  task automatic test_priority();
    bit ok;
    fill_nops();
    do_reset();
    step();
    step();
    id_redirect_valid = 1'b1; id_redirect_addr = 32'h200;
    ex_redirect_valid = 1'b1; ex_redirect_addr = 32'h300;
    step();
    id_redirect_valid = 1'b0; ex_redirect_valid = 1'b0;
    n_checks++;
    if (id_q_valid !== 1'b0) begin n_fail++; $display("FAIL prio_clear: got %b expected 0", id_q_valid); end
    ok = 1'b0;
    for (int unsigned k = 0; k < 20 && !ok; k++) begin
      step();
      if (acc_seen) ok = 1'b1;
    end
    n_checks++;
    if (!(ok && acc_addr === 32'h300)) begin
      n_fail++; $display("FAIL prio_req: got %b addr %h expected 1 addr 00000300", ok, acc_addr);
    end
    wait_entry(20, ok);
    n_checks++;
    if (!(ok && id_q_pc === 32'h300)) begin n_fail++; $display("FAIL prio_entry: got pc %h expected 00000300", id_q_pc); end
    id_stall = 1'b1; id_redirect_valid = 1'b1; id_redirect_addr = 32'h200;
    step();
    id_redirect_valid = 1'b0;
    step();
    id_stall = 1'b0;
    wait_entry(20, ok);
    n_checks++;
    if (!(ok && id_q_pc === 32'h304)) begin
      n_fail++; $display("FAIL prio_stalled_id: got %b pc %h expected 1 pc 00000304", ok, id_q_pc);
    end
  endtask

  task automatic test_trap();
    bit ok;
    fill_nops();
    do_reset();
    step();
    step();
    ex_redirect_valid = 1'b1; ex_redirect_trap = 1'b1; ex_redirect_addr = 32'h80;
    step();
    ex_redirect_valid = 1'b0; ex_redirect_trap = 1'b0;
    wait_entry(20, ok);
    n_checks++;
    if (!(ok && id_q_pc === 32'h80 && id_q_intr === 1'b1)) begin
      n_fail++; $display("FAIL trap_first: got pc %h intr %b expected pc 00000080 intr 1", id_q_pc, id_q_intr);
    end
    wait_entry(20, ok);
    n_checks++;
    if (!(ok && id_q_pc === 32'h84 && id_q_intr === 1'b0)) begin
      n_fail++; $display("FAIL trap_next: got pc %h intr %b expected pc 00000084 intr 0", id_q_pc, id_q_intr);
    end
  endtask

  // Model: expected fetch stream is sequential PCs interrupted by redirects;
  // predictor is a table of saturating counters indexed by pc bits xor history.
  task automatic test_random();
    int unsigned m_pht [64];
    logic [5:0]  m_ghr, mi, ui;
    logic [31:0] exp_pc, exa, ida, w;
    bit          m_pend, exv, idv, st, trp, upd, tk, exp_bt;
    int unsigned entries;
    logic        s_valid, s_intr, s_bt;
    logic [31:0] s_pc, s_insn;
    logic [5:0]  s_idx;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      w[6:0] = (($urandom % 4) == 0) ? 7'b1100011 : 7'b0010011;
      imem[i] = w;
    end
    lat_min = 1; lat_max = 3; rdy_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_ghr = '0; exp_pc = 32'h0; m_pend = 1'b0; entries = 0;
    for (int unsigned i = 0; i < 800; i++) begin
      st  = ($urandom % 100) < 30;
      exv = ($urandom % 100) < 4;
      idv = ($urandom % 100) < 5;
      trp = exv && (($urandom % 2) == 1);
      exa = {22'd0, 8'($urandom), 2'b00};
      ida = {22'd0, 8'($urandom), 2'b00};
      upd = !st && (($urandom % 100) < 25);
      ui  = 6'($urandom);
      tk  = ($urandom % 2) == 1;
      id_stall = st; ex_redirect_valid = exv; ex_redirect_addr = exa; ex_redirect_trap = trp;
      id_redirect_valid = idv; id_redirect_addr = ida;
      ex_pht_update_valid = upd; ex_pht_idx = ui; ex_branch_taken = tk;
      s_valid = id_q_valid; s_pc = id_q_pc; s_insn = id_q_insn;
      s_bt = id_predict_btaken; s_idx = id_pht_idx; s_intr = id_q_intr;
      step();
      if (exv || (idv && !st)) begin
        n_checks++;
        if (id_q_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redirect_clear: cycle %0d got valid %b expected 0", i, id_q_valid); end
      end else if (st) begin
        n_checks++;
        if ({id_q_valid, id_q_pc, id_q_insn, id_predict_btaken, id_pht_idx, id_q_intr} !== {s_valid, s_pc, s_insn, s_bt, s_idx, s_intr}) begin
          n_fail++; $display("FAIL rnd_stall_hold: cycle %0d got valid %b pc %h expected valid %b pc %h", i, id_q_valid, id_q_pc, s_valid, s_pc);
        end
      end else if (id_q_valid) begin
        mi = exp_pc[7:2] ^ m_ghr;
        exp_bt = (imem[exp_pc[9:2]][6:0] == 7'b1100011) && (m_pht[mi] >= 2);
        n_checks++;
        if (id_q_pc !== exp_pc || id_q_insn !== imem[exp_pc[9:2]] || id_q_pc_plus_4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL rnd_entry: cycle %0d got pc %h insn %h pc4 %h expected pc %h insn %h", i, id_q_pc, id_q_insn, id_q_pc_plus_4, exp_pc, imem[exp_pc[9:2]]);
        end
        n_checks++;
        if (id_predict_btaken !== exp_bt || id_pht_idx !== mi || id_q_intr !== m_pend) begin
          n_fail++; $display("FAIL rnd_predict: cycle %0d got bt %b idx %0d intr %b expected bt %b idx %0d intr %b", i, id_predict_btaken, id_pht_idx, id_q_intr, exp_bt, mi, m_pend);
        end
        m_pend = 1'b0;
        exp_pc = exp_pc + 32'd4;
        entries++;
      end
      if (exv) exp_pc = exa;
      else if (idv && !st) exp_pc = ida;
      if (exv && trp) m_pend = 1'b1;
      if (upd) begin
        if (tk && m_pht[ui] != 3) m_pht[ui]++;
        else if (!tk && m_pht[ui] != 0) m_pht[ui]--;
        m_ghr = {m_ghr[4:0], tk};
      end
    end
    id_stall = 1'b0; ex_redirect_valid = 1'b0; id_redirect_valid = 1'b0;
    ex_redirect_trap = 1'b0; ex_pht_update_valid = 1'b0;
    rdy_rand = 1'b0; lat_min = 1; lat_max = 1;
    n_checks++;
    if (entries < 40) begin n_fail++; $display("FAIL rnd_progress: got %0d entries expected at least 40", entries); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_drop();
    test_pht_training();
    test_priority();
    test_trap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
